// File: rtl/debounce_pkg.sv
// Shared types and limits for the sig_debounce block.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } state_t;

  localparam int STABLE_CYCLES_MAX = 255;

endpackage

// File: rtl/or2.sv
// Two-input OR gate primitive; its output is the raw level fed to the debouncer.
module or2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a | b;

endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sig_debounce.sv
// Level debouncer: accepts a din change only after STABLE_CYCLES identical samples.
// Define SIG_DEBOUNCE_SYNC_EN to insert a sync2 stage ahead of the FSM (+2 cycles latency).
//
// state     | meaning
// ----------|----------------------------------------------
// IDLE_LOW  | dout=0 accepted, waiting for a 1 sample
// CHK_HIGH  | counting consecutive 1 samples toward dout=1
// IDLE_HIGH | dout=1 accepted, waiting for a 0 sample
// CHK_LOW   | counting consecutive 0 samples toward dout=0
module sig_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          din_s;
  state_t        state;
  logic [CW-1:0] cnt;

`ifdef SIG_DEBOUNCE_SYNC_EN
  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );
`else
  assign din_s = din;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (din_s) begin
            state <= CHK_HIGH;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        CHK_HIGH: begin
          if (!din_s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!din_s) begin
            state <= CHK_LOW;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        CHK_LOW: begin
          if (din_s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_debounce.sv
// Scoreboard bench for sig_debounce: din comes from an or2, expectations from a sample-history model.
module tb_sig_debounce;

  localparam int N = 4;
`ifdef SIG_DEBOUNCE_SYNC_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N;
`endif

  typedef struct packed {
    logic dout;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic y;
  logic dout, rise, fall, busy;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];

  always #5 clk = ~clk;

  or2 u_or2 (
    .a (a),
    .b (b),
    .y (y)
  );

  sig_debounce #(.STABLE_CYCLES(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (y),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  // Reference: dout flips when the last N samples all disagree with it.
  bit   hist[$];
  logic m_dout;
`ifdef SIG_DEBOUNCE_SYNC_EN
  bit   dq[$];
`endif

  always @(posedge clk or posedge rst) begin
    exp_t e;
    bit   s;
    bit   flip;
    if (rst) begin
      m_dout = 1'b0;
      hist.delete();
`ifdef SIG_DEBOUNCE_SYNC_EN
      dq.delete();
      dq.push_back(1'b0);
      dq.push_back(1'b0);
`endif
      sb.delete();
      e = '0;
      sb.push_back(e);
    end else begin
`ifdef SIG_DEBOUNCE_SYNC_EN
      dq.push_back(a | b);
      s = dq.pop_front();
`else
      s = a | b;
`endif
      hist.push_back(s);
      if (hist.size() > N) void'(hist.pop_front());
      flip = (hist.size() == N);
      foreach (hist[i]) if (hist[i] == m_dout) flip = 1'b0;
      e.rise = flip && !m_dout;
      e.fall = flip && m_dout;
      if (flip) m_dout = !m_dout;
      e.dout = m_dout;
      e.busy = (hist[hist.size()-1] != m_dout);
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    got = {dout, rise, fall, busy};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty t=%0t got dout=%b rise=%b fall=%b busy=%b",
               $time, dout, rise, fall, busy);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL monitor t=%0t got dout=%b rise=%b fall=%b busy=%b want dout=%b rise=%b fall=%b busy=%b",
                 $time, dout, rise, fall, busy, e.dout, e.rise, e.fall, e.busy);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts edges (from a stimulus change at posedge+2) until dout reaches want,
  // then checks the edge count and the one-cycle edge pulse.
  task automatic measure(input string nm, input logic want, input int exp_n);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (dout === want) seen = 1;
    end
    checks++;
    if (!seen || n != exp_n) begin
      failures++;
      $display("FAIL %s_latency edges=%0d seen=%0d required=%0d", nm, n, seen, exp_n);
    end
    checks++;
    if ((want ? rise : fall) !== 1'b1 || (rise & fall) !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse rise=%b fall=%b required %s", nm, rise, fall, want ? "rise" : "fall");
    end
    @(posedge clk);
    #1;
    checks++;
    if (rise !== 1'b0 || fall !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse_width rise=%b fall=%b required 0", nm, rise, fall);
    end
    #1;
  endtask

  initial begin
    bit   saw_rise;
    int   lvl, len, sel;
    #2 rst = 1'b1;
    step(2);
    rst = 1'b0;

    // Idle low: nothing should move.
    step(10);

    // A=1 held: dout rises LAT edges later.
    a = 1'b1;
    measure("a_rise", 1'b1, LAT);
    step(3);

    // Both inputs low for long enough: dout falls LAT edges later.
    a = 1'b0;
    b = 1'b0;
    measure("drop_fall", 1'b0, LAT);
    step(2);

    // Glitch of N-1 samples on B must not reach dout.
    saw_rise = 0;
    b = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      @(posedge clk);
      #1;
      if (rise) saw_rise = 1;
      #1;
    end
    b = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      #1;
      if (rise) saw_rise = 1;
      #1;
    end
    checks++;
    if (saw_rise || dout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch saw_rise=%0d dout=%b busy=%b required 0 0 0", saw_rise, dout, busy);
    end

    // Async reset in the middle of a high check.
    a = 1'b1;
    step(2);
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, rise, fall, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got dout=%b rise=%b fall=%b busy=%b required all 0",
               dout, rise, fall, busy);
    end
    #1;
    step(2);
    rst = 1'b0;
    measure("post_reset_rise", 1'b1, LAT);
    step(2);

    // Random segments of held levels, mixing glitches and accepted changes.
    for (int k = 0; k < 80; k++) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      sel = int'($urandom_range(1, 3));
      a = (lvl != 0) && (sel != 2);
      b = (lvl != 0) && (sel != 1);
      step(len);
    end
    a = 1'b0;
    b = 1'b0;
    step(LAT + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
